// File: rtl/amm_burst_master.sv
// -----------------------------------------------------------------------------
// amm_burst_master
// Avalon-MM burst traffic engine. Each accepted command issues either one
// write burst carrying a seed-based pattern, or one read burst whose returned
// beats are compared against the same pattern. The mismatch count and a read
// timeout flag are reported back at command completion.
//
// Pattern: beat k carries DATA_W/32 copies of (seed + k) mod 2^32.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0 = write burst, 1 = read-and-check burst
//   cmd_addr              start word address
//   cmd_burst             beat count (0 = complete without bus activity)
//   cmd_seed              pattern seed
//   amm_*                 Avalon-MM master signals
//   done                  one-cycle completion pulse
//   err_cnt               mismatching read beats of the last command
//   timeout               last read command aborted on inter-beat timeout
// -----------------------------------------------------------------------------
module amm_burst_master #(
  parameter int ADDR_W  = 31,
  parameter int DATA_W  = 128,
  parameter int BURST_W = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [BURST_W-1:0]  cmd_burst,
  input  logic [31:0]         cmd_seed,
  output logic [ADDR_W-1:0]   amm_address,
  output logic [BURST_W-1:0]  amm_burstcount,
  output logic                amm_read,
  output logic                amm_write,
  output logic [DATA_W-1:0]   amm_writedata,
  output logic [DATA_W/8-1:0] amm_byteenable,
  input  logic [DATA_W-1:0]   amm_readdata,
  input  logic                amm_readdatavalid,
  input  logic                amm_waitrequest,
  output logic                done,
  output logic [BURST_W-1:0]  err_cnt,
  output logic                timeout
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [BURST_W-1:0] BEAT_ONE  = BURST_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_DATA = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  // Replicate one 32-bit pattern word across the data bus.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [31:0] word);
    f_pattern = {(DATA_W / 32){word}};
  endfunction

  state_t               r_state,          w_state;
  logic [BURST_W-1:0]   r_burst,          w_burst;
  logic [31:0]          r_seed,           w_seed;
  logic [BURST_W-1:0]   r_beat,           w_beat;
  logic [IDLE_W-1:0]    r_idle,           w_idle;
  logic                 r_cmd_ready,      w_cmd_ready;
  logic [ADDR_W-1:0]    r_amm_address,    w_amm_address;
  logic [BURST_W-1:0]   r_amm_burstcount, w_amm_burstcount;
  logic                 r_amm_read,       w_amm_read;
  logic                 r_amm_write,      w_amm_write;
  logic [DATA_W-1:0]    r_amm_writedata,  w_amm_writedata;
  logic [BE_W-1:0]      r_amm_byteenable, w_amm_byteenable;
  logic                 r_done,           w_done;
  logic [BURST_W-1:0]   r_err_cnt,        w_err_cnt;
  logic                 r_timeout,        w_timeout;
  logic                 w_bus_clr;
  logic                 w_last_beat;

  // Last beat of the burst is the one whose 0-based index is burst-1.
  assign w_last_beat = (r_beat == (r_burst - BEAT_ONE));

  // Next-state and next-output logic.
  always_comb begin
    w_state          = r_state;
    w_burst          = r_burst;
    w_seed           = r_seed;
    w_beat           = r_beat;
    w_idle           = r_idle;
    w_cmd_ready      = r_cmd_ready;
    w_amm_address    = r_amm_address;
    w_amm_burstcount = r_amm_burstcount;
    w_amm_read       = r_amm_read;
    w_amm_write      = r_amm_write;
    w_amm_writedata  = r_amm_writedata;
    w_amm_byteenable = r_amm_byteenable;
    w_done           = 1'b0;
    w_err_cnt        = r_err_cnt;
    w_timeout        = r_timeout;
    w_bus_clr        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        // r_cmd_ready gates acceptance so the first cycle after reset is not ready.
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready = 1'b0;
          w_burst     = cmd_burst;
          w_seed      = cmd_seed;
          w_beat      = '0;
          w_idle      = '0;
          w_err_cnt   = '0;
          w_timeout   = 1'b0;
          if (cmd_burst == '0) begin
            w_state = S_FIN;
          end else begin
            w_amm_address    = cmd_addr;
            w_amm_burstcount = cmd_burst;
            w_amm_byteenable = {BE_W{1'b1}};
            if (cmd_op == 1'b0) begin
              w_state         = S_WR;
              w_amm_write     = 1'b1;
              w_amm_writedata = f_pattern(cmd_seed);
            end else begin
              w_state    = S_RD_REQ;
              w_amm_read = 1'b1;
            end
          end
        end else begin
          w_state = S_IDLE;
        end
      end

      S_WR: begin
        if (!amm_waitrequest) begin
          w_beat = r_beat + BEAT_ONE;
          if (w_last_beat) begin
            w_state   = S_FIN;
            w_done    = 1'b1;
            w_bus_clr = 1'b1;
          end else begin
            w_amm_writedata = f_pattern(r_seed + 32'(r_beat) + 32'd1);
          end
        end else begin
          w_state = S_WR;
        end
      end

      S_RD_REQ: begin
        if (!amm_waitrequest) begin
          w_state   = S_RD_DATA;
          w_idle    = '0;
          w_bus_clr = 1'b1;
        end else begin
          w_state = S_RD_REQ;
        end
      end

      S_RD_DATA: begin
        if (amm_readdatavalid) begin
          w_idle = '0;
          w_beat = r_beat + BEAT_ONE;
          if (amm_readdata != f_pattern(r_seed + 32'(r_beat))) begin
            w_err_cnt = r_err_cnt + BEAT_ONE;
          end else begin
            w_err_cnt = r_err_cnt;
          end
          if (w_last_beat) begin
            w_state = S_FIN;
            w_done  = 1'b1;
          end else begin
            w_state = S_RD_DATA;
          end
        end else if (r_idle == IDLE_LAST) begin
          // TIMEOUT consecutive cycles without a beat: abandon the read.
          w_state   = S_FIN;
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_idle = r_idle + IDLE_ONE;
        end
      end

      S_FIN: begin
        // Bursts enter FIN with done already raised; a zero-beat command
        // arrives with done low and spends one extra cycle raising it.
        if (r_done) begin
          w_state     = S_IDLE;
          w_cmd_ready = 1'b1;
        end else begin
          w_done = 1'b1;
        end
      end

      default: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b0;
        w_bus_clr   = 1'b1;
      end
    endcase

    // Drop all bus outputs once a transfer phase is over.
    if (w_bus_clr) begin
      w_amm_address    = '0;
      w_amm_burstcount = '0;
      w_amm_read       = 1'b0;
      w_amm_write      = 1'b0;
      w_amm_writedata  = '0;
      w_amm_byteenable = '0;
    end else begin
      w_amm_read = w_amm_read;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_burst          <= '0;
      r_seed           <= 32'd0;
      r_beat           <= '0;
      r_idle           <= '0;
      r_cmd_ready      <= 1'b0;
      r_amm_address    <= '0;
      r_amm_burstcount <= '0;
      r_amm_read       <= 1'b0;
      r_amm_write      <= 1'b0;
      r_amm_writedata  <= '0;
      r_amm_byteenable <= '0;
      r_done           <= 1'b0;
      r_err_cnt        <= '0;
      r_timeout        <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_burst          <= w_burst;
      r_seed           <= w_seed;
      r_beat           <= w_beat;
      r_idle           <= w_idle;
      r_cmd_ready      <= w_cmd_ready;
      r_amm_address    <= w_amm_address;
      r_amm_burstcount <= w_amm_burstcount;
      r_amm_read       <= w_amm_read;
      r_amm_write      <= w_amm_write;
      r_amm_writedata  <= w_amm_writedata;
      r_amm_byteenable <= w_amm_byteenable;
      r_done           <= w_done;
      r_err_cnt        <= w_err_cnt;
      r_timeout        <= w_timeout;
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign amm_address    = r_amm_address;
  assign amm_burstcount = r_amm_burstcount;
  assign amm_read       = r_amm_read;
  assign amm_write      = r_amm_write;
  assign amm_writedata  = r_amm_writedata;
  assign amm_byteenable = r_amm_byteenable;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_amm_burst_master.sv
// -----------------------------------------------------------------------------
// tb_amm_burst_master
// Directed bench for amm_burst_master. A transaction-level model follows each
// command (accept, beats, completion) from the handshake rules and predicts
// the bus outputs, done, err_cnt and timeout every cycle; directed tests add
// hand-computed literal expectations on latencies, beat counts and data.
// -----------------------------------------------------------------------------
module tb_amm_burst_master;

  localparam int ADDR_W  = 31;
  localparam int DATA_W  = 128;
  localparam int BURST_W = 11;
  localparam int TIMEOUT = 16;
  localparam int BE_W    = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_op = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [BURST_W-1:0]  cmd_burst = '0;
  logic [31:0]         cmd_seed = 32'd0;
  logic [ADDR_W-1:0]   amm_address;
  logic [BURST_W-1:0]  amm_burstcount;
  logic                amm_read;
  logic                amm_write;
  logic [DATA_W-1:0]   amm_writedata;
  logic [BE_W-1:0]     amm_byteenable;
  logic [DATA_W-1:0]   amm_readdata = '0;
  logic                amm_readdatavalid = 1'b0;
  logic                amm_waitrequest = 1'b0;
  logic                done;
  logic [BURST_W-1:0]  err_cnt;
  logic                timeout;

  amm_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_seed(cmd_seed),
    .amm_address(amm_address), .amm_burstcount(amm_burstcount),
    .amm_read(amm_read), .amm_write(amm_write),
    .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
    .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
    .amm_waitrequest(amm_waitrequest),
    .done(done), .err_cnt(err_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] w);
    pat = {(DATA_W / 32){w}};
  endfunction

  // ---------------- transaction model ----------------
  typedef enum int {P_IDLE, P_WR, P_RQ, P_RD, P_ZW, P_DN} phase_t;
  phase_t            ph = P_IDLE;
  bit                m_first = 1'b1;
  logic [ADDR_W-1:0] m_addr;
  int                m_burst, m_k, m_idle, m_err;
  logic [31:0]       m_seed;
  bit                m_to;
  // per-command statistics for literal expectations
  int                cyc = 0, acc_cyc = 0, done_cyc = 0;
  int                n_wr_cyc = 0, n_rd_cyc = 0, n_done = 0, n_wacc = 0;
  int                last_err = 0;
  bit                last_to = 1'b0;
  logic [DATA_W-1:0] first_wdata, last_wdata;

  always @(negedge clk) begin
    bit rdy;
    cyc++;
    if (!rst_n) begin
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_write", amm_write, 1'b0);
      check("rst_read", amm_read, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err_cnt", err_cnt, '0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_byteenable", amm_byteenable, '0);
      check("rst_address", amm_address, '0);
      ph = P_IDLE; m_first = 1'b1; m_err = 0; m_to = 1'b0; m_k = 0;
    end else begin
      rdy = (ph == P_IDLE) && !m_first;
      check("cmd_ready", cmd_ready, rdy);
      check("amm_write", amm_write, ph == P_WR);
      check("amm_read", amm_read, ph == P_RQ);
      check("done", done, ph == P_DN);
      check("byteenable", amm_byteenable, (ph == P_WR || ph == P_RQ) ? {BE_W{1'b1}} : {BE_W{1'b0}});
      if (ph == P_WR || ph == P_RQ) begin
        check("address", amm_address, m_addr);
        check("burstcount", amm_burstcount, m_burst);
      end
      if (ph == P_WR) check("writedata", amm_writedata, pat(m_seed + 32'(m_k)));
      if (ph == P_DN || (ph == P_IDLE && !m_first)) begin
        check("err_cnt", err_cnt, m_err);
        check("timeout", timeout, m_to);
      end

      if (amm_write) n_wr_cyc++;
      if (amm_read) n_rd_cyc++;
      if (amm_write && !amm_waitrequest) begin
        if (n_wacc == 0) first_wdata = amm_writedata;
        last_wdata = amm_writedata;
        n_wacc++;
      end
      if (done) begin
        n_done++; done_cyc = cyc; last_err = int'(err_cnt); last_to = timeout;
      end

      m_first = 1'b0;
      case (ph)
        P_IDLE: if (rdy && cmd_valid) begin
          m_addr = cmd_addr; m_burst = int'(cmd_burst); m_seed = cmd_seed;
          m_k = 0; m_err = 0; m_to = 1'b0; m_idle = 0;
          acc_cyc = cyc; n_wr_cyc = 0; n_rd_cyc = 0; n_done = 0; n_wacc = 0;
          if (m_burst == 0) ph = P_ZW;
          else if (cmd_op) ph = P_RQ;
          else ph = P_WR;
        end
        P_WR: if (!amm_waitrequest) begin
          m_k++;
          if (m_k == m_burst) ph = P_DN;
        end
        P_RQ: if (!amm_waitrequest) begin
          ph = P_RD; m_idle = 0;
        end
        P_RD: if (amm_readdatavalid) begin
          if (amm_readdata !== pat(m_seed + 32'(m_k))) m_err++;
          m_k++; m_idle = 0;
          if (m_k == m_burst) ph = P_DN;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_to = 1'b1; ph = P_DN; end
        end
        P_ZW: ph = P_DN;
        P_DN: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a command and return in the first cycle after acceptance.
  task automatic send(input logic op, input logic [ADDR_W-1:0] a,
                      input logic [BURST_W-1:0] b, input logic [31:0] s);
    bit got = 1'b0;
    cmd_op = op; cmd_addr = a; cmd_burst = b; cmd_seed = s; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    check("cmd_accepted", got, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rd_beat(input logic [31:0] w);
    amm_readdatavalid = 1'b1; amm_readdata = pat(w);
    tick();
    amm_readdatavalid = 1'b0; amm_readdata = '0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();

    // T1: write 4 beats, no stalls
    send(1'b0, 31'h100, 11'd4, 32'h10);
    wait_done(20);
    check("t1_wr_cycles", n_wr_cyc, 4);
    check("t1_done_latency", done_cyc - acc_cyc, 5);
    check("t1_first_data", first_wdata, 128'h00000010_00000010_00000010_00000010);
    check("t1_last_data", last_wdata, 128'h00000013_00000013_00000013_00000013);

    // T2: write 3 beats, beat 1 stalled 2 cycles
    send(1'b0, 31'h40, 11'd3, 32'hA0);
    tick(); amm_waitrequest = 1'b1;
    tick();
    tick(); amm_waitrequest = 1'b0;
    wait_done(20);
    check("t2_wr_cycles", n_wr_cyc, 5);
    check("t2_done_latency", done_cyc - acc_cyc, 6);
    check("t2_done_count", n_done, 1);

    // T3: read 4 beats with gaps, third beat corrupt
    send(1'b1, 31'h200, 11'd4, 32'h10);
    amm_waitrequest = 1'b1;
    tick(); amm_waitrequest = 1'b0;
    tick(); tick();
    rd_beat(32'h10);
    tick();
    rd_beat(32'h11);
    rd_beat(32'hFF);
    tick();
    rd_beat(32'h13);
    wait_done(10);
    check("t3_err_cnt", last_err, 1);
    check("t3_timeout", last_to, 1'b0);
    check("t3_done_latency", done_cyc - acc_cyc, 10);
    check("t3_rd_cycles", n_rd_cyc, 2);

    // T4: read 2 beats, slave returns one then goes silent
    send(1'b1, 31'h300, 11'd2, 32'h50);
    tick(); tick();
    rd_beat(32'h50);
    wait_done(TIMEOUT + 10);
    check("t4_timeout", last_to, 1'b1);
    check("t4_err_cnt", last_err, 0);
    check("t4_done_latency", done_cyc - acc_cyc, 4 + TIMEOUT);
    rd_beat(32'h99);
    tick(); tick();
    check("t4_late_no_done", n_done, 1);
    check("t4_late_err_cnt", err_cnt, 11'd0);

    // T5: zero-beat command
    send(1'b0, 31'h500, 11'd0, 32'h1);
    wait_done(10);
    check("t5_done_latency", done_cyc - acc_cyc, 2);
    check("t5_no_write", n_wr_cyc, 0);
    check("t5_no_read", n_rd_cyc, 0);
    check("t5_timeout_cleared", last_to, 1'b0);

    // T6: reset during write beat 2 of 8, then a normal command
    send(1'b0, 31'h600, 11'd8, 32'h77);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t6_async_write", amm_write, 1'b0);
    check("t6_async_ready", cmd_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("t6_ready_after", cmd_ready, 1'b1);
    send(1'b0, 31'h700, 11'd2, 32'hC0);
    wait_done(10);
    check("t6_wr_cycles", n_wr_cyc, 2);
    check("t6_done_latency", done_cyc - acc_cyc, 3);
    check("t6_last_data", last_wdata, 128'h000000C1_000000C1_000000C1_000000C1);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
